// File: rtl/sd_read_scheduler.sv
// Round-robin block-read scheduler for the simulation SD helper: grants one of two
// requesters, strobes the start address, then streams words through a response FIFO.
module sd_read_scheduler #(
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_addr,
   input  logic [LEN_W-1:0] req0_len,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_addr,
   input  logic [LEN_W-1:0] req1_len,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_data,
   output logic             resp_id,
   output logic             resp_last,
   output logic             busy,
   output logic             sd_setAddr,
   output logic [31:0]      sd_addr,
   output logic             sd_ren,
   input  logic [31:0]      sd_data
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]      DEPTH_C = FIFO_DEPTH[AW:0];
   localparam logic [AW:0]      CNT_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0]    PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, SETADDR, READ, DRAIN} state_t;
   state_t state, state_next;

   logic             rr_last;   // 1: requester 1 was served last
   logic [31:0]      addr_q;
   logic [LEN_W-1:0] len_q;
   logic             id_q;
   logic [LEN_W-1:0] remaining;
   logic [LEN_W-1:0] issued;
   logic             inflight;

   logic [31:0]   mem_data [FIFO_DEPTH];
   logic          mem_id   [FIFO_DEPTH];
   logic          mem_last [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   fifo_count;
   logic [AW:0]   occupancy;

   logic             grant0, grant1, take, push, pop, head_last;
   logic [LEN_W-1:0] sel_len;

   // NOTE: every signal written in always_comb gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      grant0     = req0_valid && (!req1_valid || rr_last);
      grant1     = req1_valid && (!req0_valid || !rr_last);
      req0_ready = !reset && (state == IDLE) && grant0;
      req1_ready = !reset && (state == IDLE) && grant1;
      take       = req0_ready || req1_ready;
      sel_len    = req1_ready ? req1_len : req0_len;

      sd_setAddr = (state == SETADDR);
      sd_addr    = sd_setAddr ? addr_q : 32'h0;
      occupancy  = fifo_count + {{AW{1'b0}}, inflight};
      sd_ren     = (state == READ) && (remaining != '0) && (occupancy < DEPTH_C);
      push       = sd_ren;

      resp_valid = (fifo_count != '0);
      head_last  = mem_last[rd_ptr];
      resp_data  = resp_valid ? mem_data[rd_ptr] : 32'h0;
      resp_id    = resp_valid && mem_id[rd_ptr];
      resp_last  = resp_valid && head_last;
      pop        = resp_valid && resp_ready;
      busy       = (state != IDLE);

      state_next = state;
      case (state)
         IDLE:    if (take) state_next = (sel_len != '0) ? SETADDR : IDLE;
         SETADDR: state_next = READ;
         READ:    if (sd_ren && remaining == LEN_ONE) state_next = DRAIN;
         DRAIN:   if (pop && head_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         rr_last    <= 1'b1;
         addr_q     <= 32'h0;
         len_q      <= '0;
         id_q       <= 1'b0;
         remaining  <= '0;
         issued     <= '0;
         inflight   <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         state    <= state_next;
         inflight <= sd_ren;
         if (take) begin
            addr_q  <= req1_ready ? req1_addr : req0_addr;
            len_q   <= sel_len;
            id_q    <= req1_ready;
            rr_last <= req1_ready;
         end
         if (state == SETADDR) begin
            remaining <= len_q;
            issued    <= '0;
         end else if (sd_ren) begin
            remaining <= remaining - LEN_ONE;
            issued    <= issued + LEN_ONE;
         end
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)      fifo_count <= fifo_count + CNT_ONE;
         else if (!push && pop) fifo_count <= fifo_count - CNT_ONE;
      end
   end

   // NOTE: storage is deliberately left out of reset; emptiness is defined by the
   // pointers and count alone, so stale entries are never observable.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= sd_data;
         mem_id[wr_ptr]   <= id_q;
         mem_last[wr_ptr] <= (issued + LEN_ONE == len_q);
      end
   end
endmodule

// File: tb/tb_sd_read_scheduler.sv
// Self-checking bench for sd_read_scheduler: helper model, per-cycle reference model,
// an arbitration table, directed corner sequences and a randomized phase.
`timescale 1ns/1ps
module tb_sd_read_scheduler;
   localparam int DEPTH = 4;
   localparam int LW    = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic [31:0]   req0_addr = 32'h0, req1_addr = 32'h0;
   logic [LW-1:0] req0_len = '0, req1_len = '0;
   logic          resp_ready = 1'b0;
   logic [31:0]   sd_data = 32'h0;
   logic          req0_ready, req1_ready, resp_valid, resp_id, resp_last, busy;
   logic          sd_setAddr, sd_ren;
   logic [31:0]   resp_data, sd_addr;

   sd_read_scheduler #(.FIFO_DEPTH(DEPTH), .LEN_W(LW)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_len(req0_len),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_len(req1_len),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_id(resp_id), .resp_last(resp_last), .busy(busy),
      .sd_setAddr(sd_setAddr), .sd_addr(sd_addr), .sd_ren(sd_ren), .sd_data(sd_data)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Contents of the helper's memory at a word address.
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
   endfunction

   typedef struct { logic [31:0] data; logic id; logic last; } beat_t;
   typedef struct { logic [31:0] data; logic id; logic last; int cyc; } obs_t;
   typedef struct { logic v0; logic v1; logic r0; logic r1; } arb_vec_t;

   // Reference model state: phase 0 idle, 1 address strobe, 2 reading, 3 draining.
   beat_t       m_q[$];
   int          m_mode = 0;
   logic        m_rr = 1'b1;
   logic [31:0] m_addr = 32'h0;
   logic [31:0] m_ptr = 32'h0;
   int          m_len = 0, m_rem = 0, m_iss = 0, m_words = 0;
   logic        m_id = 1'b0, m_inflight = 1'b0;
   bit          mon_en = 1'b0;

   logic [31:0] h_ptr = 32'h0;
   int          set_cnt = 0, ren_cnt = 0, set_cyc = 0, first_ren_cyc = 0, last_ren_cyc = 0, busy_last = 0;
   logic [31:0] set_addr_seen = 32'h0;
   obs_t        beats[$];
   logic        grants[$];

   task automatic model_step();
      logic g0, g1, e_r0, e_r1, e_set, e_ren, e_valid, e_id, e_last, pop, popped_last, final_issue;
      logic [31:0] e_addr, e_data;
      g0      = req0_valid && (!req1_valid || m_rr);
      g1      = req1_valid && (!req0_valid || !m_rr);
      e_r0    = !reset && m_mode == 0 && g0;
      e_r1    = !reset && m_mode == 0 && g1;
      e_set   = (m_mode == 1);
      e_addr  = e_set ? m_addr : 32'h0;
      e_ren   = (m_mode == 2) && (m_rem > 0) && (m_q.size() + int'(m_inflight) < DEPTH);
      e_valid = (m_q.size() > 0);
      e_data  = e_valid ? m_q[0].data : 32'h0;
      e_id    = e_valid ? m_q[0].id : 1'b0;
      e_last  = e_valid ? m_q[0].last : 1'b0;
      if (mon_en) begin
         check("model_ctl",
               64'({req0_ready, req1_ready, sd_setAddr, sd_ren, resp_valid, resp_id, resp_last, busy}),
               64'({e_r0, e_r1, e_set, e_ren, e_valid, e_id, e_last, m_mode != 0}));
         check("model_sd_addr", 64'(sd_addr), 64'(e_addr));
         check("model_resp_data", 64'(resp_data), 64'(e_data));
      end
      if (reset) begin
         m_mode = 0; m_rr = 1'b1; m_q.delete(); m_rem = 0; m_inflight = 1'b0;
      end else begin
         pop         = e_valid && resp_ready;
         popped_last = pop && m_q[0].last;
         final_issue = e_ren && m_rem == 1;
         if (pop) void'(m_q.pop_front());
         if (e_ren) begin
            m_iss++;
            m_q.push_back('{word_at(m_ptr), m_id, m_iss == m_len});
            m_ptr++;
            m_rem--;
         end
         case (m_mode)
            0: if (e_r0 || e_r1) begin
                  m_id    = e_r1;
                  m_addr  = e_r1 ? req1_addr : req0_addr;
                  m_len   = e_r1 ? int'(req1_len) : int'(req0_len);
                  m_rr    = e_r1;
                  m_words += m_len;
                  if (m_len != 0) m_mode = 1;
               end
            1: begin m_ptr = m_addr; m_rem = m_len; m_iss = 0; m_mode = 2; end
            2: if (final_issue) m_mode = 3;
            default: if (popped_last) m_mode = 0;
         endcase
         m_inflight = e_ren;
      end
   endtask

   task automatic observe();
      if (sd_setAddr === 1'b1) begin set_cnt++; set_addr_seen = sd_addr; set_cyc = cyc; end
      if (sd_ren === 1'b1) begin
         if (ren_cnt == 0) first_ren_cyc = cyc;
         ren_cnt++;
         last_ren_cyc = cyc;
      end
      if (resp_valid === 1'b1 && resp_ready) beats.push_back('{resp_data, resp_id, resp_last, cyc});
      if (req0_ready === 1'b1) grants.push_back(1'b0);
      if (req1_ready === 1'b1) grants.push_back(1'b1);
      if (busy === 1'b1) busy_last = cyc;
   endtask

   // Helper drives read data on the negedge of a read-enable cycle.
   initial forever begin
      @(negedge clk);
      model_step();
      observe();
      if (sd_setAddr === 1'b1) h_ptr = sd_addr;
      if (sd_ren === 1'b1) begin sd_data = word_at(h_ptr); h_ptr++; end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic clear_logs();
      set_cnt = 0; ren_cnt = 0; m_words = 0;
      beats.delete();
      grants.delete();
   endtask

   task automatic request(input logic id, input logic [31:0] a, input logic [LW-1:0] l, output int hs);
      bit got;
      got = 1'b0;
      hs  = -1;
      if (id) begin req1_valid = 1'b1; req1_addr = a; req1_len = l; end
      else begin req0_valid = 1'b1; req0_addr = a; req0_len = l; end
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if ((id ? req1_ready : req0_ready) === 1'b1) begin got = 1'b1; hs = cyc; end
         @(posedge clk); #1;
      end
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
      if (!got) check("req_timeout", 64'(0), 64'(1));
   endtask

   task automatic check_beats(input string name, input logic id, input logic [31:0] base, input int n);
      check({name, "_count"}, 64'(beats.size()), 64'(n));
      for (int i = 0; i < n && i < beats.size(); i++)
         check($sformatf("%s_beat%0d", name, i),
               64'({beats[i].data, beats[i].id, beats[i].last}),
               64'({word_at(base + 32'(i)), id, i == n - 1}));
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
      $fatal(1);
   end

   initial begin
      arb_vec_t tbl[8];
      int hs, n_before, r_before, s_before;
      bit g0, g1;
      // Zero-length requests keep the scheduler in IDLE while the rr pointer moves.
      tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0};

      // Reset, with both requesters pending to show ready is held low.
      req0_valid = 1'b1; req1_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_ctl",
            64'({req0_ready, req1_ready, sd_setAddr, sd_ren, resp_valid, resp_id, resp_last, busy}), 64'(0));
      check("reset_sd_addr", 64'(sd_addr), 64'(0));
      check("reset_resp_data", 64'(resp_data), 64'(0));
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      reset = 1'b0;
      mon_en = 1'b1;

      for (int i = 0; i < 8; i++) begin
         req0_valid = tbl[i].v0; req1_valid = tbl[i].v1; req0_len = '0; req1_len = '0;
         @(negedge clk);
         check($sformatf("arb_ready%0d", i), 64'({req0_ready, req1_ready}), 64'({tbl[i].r0, tbl[i].r1}));
         check($sformatf("arb_quiet%0d", i), 64'({sd_setAddr, sd_ren, resp_valid, busy}), 64'(0));
         @(posedge clk); #1;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("zero_len_no_sd", 64'(set_cnt + ren_cnt + beats.size()), 64'(0));

      // Single request with the consumer always ready.
      resp_ready = 1'b1;
      clear_logs();
      request(1'b0, 32'h100, 8'd4, hs);
      tick(10);
      check("single_set_cnt", 64'(set_cnt), 64'(1));
      check("single_set_cyc", 64'(set_cyc), 64'(hs + 1));
      check("single_addr", 64'(set_addr_seen), 64'(32'h100));
      check("single_ren_cnt", 64'(ren_cnt), 64'(4));
      check("single_ren_first", 64'(first_ren_cyc), 64'(hs + 2));
      check("single_ren_last", 64'(last_ren_cyc), 64'(hs + 5));
      check_beats("single", 1'b0, 32'h100, 4);
      if (beats.size() > 0) check("single_first_beat_cyc", 64'(beats[0].cyc), 64'(hs + 3));
      check("single_busy_end", 64'(busy_last), 64'(hs + 6));

      // Backpressure: reads stall once the FIFO fills, then resume.
      resp_ready = 1'b0;
      clear_logs();
      request(1'b0, 32'h2000, 8'd8, hs);
      tick(20);
      check("bp_ren_stall", 64'(ren_cnt), 64'(4));
      check("bp_no_beats", 64'(beats.size()), 64'(0));
      check("bp_valid_held", 64'(resp_valid), 64'(1));
      resp_ready = 1'b1;
      tick(20);
      check("bp_ren_total", 64'(ren_cnt), 64'(8));
      check_beats("bp", 1'b0, 32'h2000, 8);

      // Continuous contention; a zero-length req1 first leaves req0 owed the next tie.
      request(1'b1, 32'h0, 8'd0, hs);
      clear_logs();
      req0_addr = 32'h3000; req0_len = 8'd2; req1_addr = 32'h4000; req1_len = 8'd2;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 400 && grants.size() < 4; i++) tick(1);
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick(20);
      check("arb_grant_count", 64'(grants.size()), 64'(4));
      for (int i = 0; i < 4 && i < grants.size(); i++)
         check($sformatf("arb_grant%0d", i), 64'(grants[i]), 64'(i % 2));
      check("arb_beat_count", 64'(beats.size()), 64'(8));
      for (int j = 0; j < 8 && j < beats.size(); j++)
         check($sformatf("arb_beat%0d", j),
               64'({beats[j].data, beats[j].id, beats[j].last}),
               64'({word_at(((j / 2) % 2 == 1 ? 32'h4000 : 32'h3000) + 32'(j % 2)), (j / 2) % 2 == 1, j % 2 == 1}));

      // Reset in the middle of a long read.
      clear_logs();
      request(1'b1, 32'h5000, 8'd16, hs);
      for (int i = 0; i < 100 && ren_cnt < 5; i++) tick(1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("rst_mid_ctl",
            64'({req0_ready, req1_ready, sd_setAddr, sd_ren, resp_valid, resp_id, resp_last, busy}), 64'(0));
      check("rst_mid_sd_addr", 64'(sd_addr), 64'(0));
      check("rst_mid_resp_data", 64'(resp_data), 64'(0));
      n_before = beats.size();
      r_before = ren_cnt;
      s_before = set_cnt;
      tick(10);
      check("rst_mid_no_beats", 64'(beats.size()), 64'(n_before));
      check("rst_mid_no_ren", 64'(ren_cnt), 64'(r_before));
      request(1'b0, 32'h6000, 8'd1, hs);
      tick(8);
      check("rst_new_set", 64'(set_cnt), 64'(s_before + 1));
      check("rst_new_addr", 64'(set_addr_seen), 64'(32'h6000));
      check("rst_new_beats", 64'(beats.size()), 64'(n_before + 1));
      if (beats.size() > 0)
         check("rst_new_word", 64'({beats[$].data, beats[$].id, beats[$].last}),
               64'({word_at(32'h6000), 1'b0, 1'b1}));

      // Maximum length with a randomly stalling consumer.
      clear_logs();
      resp_ready = 1'b1;
      request(1'b0, 32'h8000, 8'd255, hs);
      for (int i = 0; i < 3000; i++) begin
         resp_ready = ($urandom_range(1) == 1);
         tick(1);
         if (beats.size() >= 255 && !busy) break;
      end
      resp_ready = 1'b1;
      tick(5);
      check("maxlen_ren", 64'(ren_cnt), 64'(255));
      check_beats("maxlen", 1'b0, 32'h8000, 255);

      // Randomized traffic from both requesters, checked cycle by cycle against the model.
      clear_logs();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         g0 = req0_ready; g1 = req1_ready;
         @(posedge clk); #1;
         if (g0) req0_valid = 1'b0;
         if (g1) req1_valid = 1'b0;
         if (!req0_valid && $urandom_range(3) == 0) begin
            req0_valid = 1'b1; req0_addr = $urandom; req0_len = LW'($urandom_range(20));
         end
         if (!req1_valid && $urandom_range(3) == 0) begin
            req1_valid = 1'b1; req1_addr = $urandom; req1_len = LW'($urandom_range(20));
         end
         resp_ready = ($urandom_range(3) != 0);
      end
      @(negedge clk);
      g0 = req0_ready; g1 = req1_ready;
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      resp_ready = 1'b1;
      tick(100);
      check("rand_idle", 64'(busy), 64'(0));
      check("rand_total_beats", 64'(beats.size()), 64'(m_words));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
